// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode codes and
// the width of the completed-transfer counter.
package imm_ext_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

  localparam int XFER_CNT_W = 16;

endpackage : imm_ext_pipe_pkg

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: zero, sign, upper-load, or
// branch offset (sign-extend then shift left 2, truncated to OUT_W bits).
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] imm_ext
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};

  // Select the extension selected by the mode code; every code is defined.
  always_comb begin
    imm_ext = '0;
    case (imm_mode_e'(mode))
      MODE_ZERO:   imm_ext = {{(OUT_W-IN_W){1'b0}}, imm_in};
      MODE_SIGN:   imm_ext = sext;
      MODE_UPPER:  imm_ext = {imm_in, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: imm_ext = {sext[OUT_W-3:0], 2'b00};
      default:     imm_ext = '0;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit with valid/ready on both sides.
// Extension happens ahead of stage 0; later stages only move data. A stage
// advances when it is empty or when the stage after it advances, so the
// pipe fills under backpressure and never inserts bubbles while flowing.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       imm_in,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      imm_out,
  output logic [1:0]            out_mode,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  logic [OUT_W-1:0]  ext_data;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [OUT_W-1:0]  data [STAGES];
  logic [1:0]        md   [STAGES];

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_in  (imm_in),
    .mode    (mode),
    .imm_ext (ext_data)
  );

  // Advance chain, resolved from the output end back toward stage 0.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~vld[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~vld[k] | adv[k+1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_v;
      logic [OUT_W-1:0] src_d;
      logic [1:0]       src_m;
      logic             v_q;
      logic [OUT_W-1:0] d_q;
      logic [1:0]       m_q;

      if (k == 0) begin : g_head
        assign src_v = in_valid;
        assign src_d = ext_data;
        assign src_m = mode;
      end else begin : g_body
        assign src_v = vld[k-1];
        assign src_d = data[k-1];
        assign src_m = md[k-1];
      end

      // Stage register: take the upstream item on advance; payload only
      // loads with a valid item so an emptied stage keeps its last value.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
          m_q <= '0;
        end else if (adv[k]) begin
          v_q <= src_v;
          if (src_v) begin
            d_q <= src_d;
            m_q <= src_m;
          end
        end
      end

      assign vld[k]  = v_q;
      assign data[k] = d_q;
      assign md[k]   = m_q;
    end
  endgenerate

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];
  assign imm_out   = data[STAGES-1];
  assign out_mode  = md[STAGES-1];

  // Completed output transfers, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (STAGES = 1, 2, 4) share the
// input stimulus; a per-instance queue model tracks accepted items and
// their expected extended values, and scenario tasks add timing checks.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] imm_in = '0;
  logic [1:0]  mode = '0;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [31:0] imm_out_w  [3];
  logic [1:0]  out_mode_w [3];
  logic [15:0] xfer_cnt_w [3];

  int total = 0;
  int bad   = 0;

  int st [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .imm_in(imm_in), .mode(mode), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .imm_out(imm_out_w[0]), .out_mode(out_mode_w[0]),
    .xfer_cnt(xfer_cnt_w[0]));

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .imm_in(imm_in), .mode(mode), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .imm_out(imm_out_w[1]), .out_mode(out_mode_w[1]),
    .xfer_cnt(xfer_cnt_w[1]));

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .imm_in(imm_in), .mode(mode), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .imm_out(imm_out_w[2]), .out_mode(out_mode_w[2]),
    .xfer_cnt(xfer_cnt_w[2]));

  // Reference extension from plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
    int u;
    int s;
    u = int'(imm);
    s = imm[15] ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(u);
      2'd1:    return 32'(s);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // ---------------- queue-based reference model ----------------
  logic [33:0] sbq [3][$];
  logic [15:0] m_cnt [3];
  logic        hold [3];
  logic [33:0] hold_v [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        sbq[d].delete();
        m_cnt[d] = '0;
        hold[d]  = 1'b0;
      end else begin
        logic exp_rdy;
        exp_rdy = out_ready || (sbq[d].size() < st[d]);
        total++;
        if (in_ready_w[d] !== exp_rdy) begin
          bad++;
          $display("FAIL sb_in_ready[S=%0d] t=%0t got=%b exp=%b", st[d], $time, in_ready_w[d], exp_rdy);
        end
        total++;
        if (xfer_cnt_w[d] !== m_cnt[d]) begin
          bad++;
          $display("FAIL sb_xfer_cnt[S=%0d] t=%0t got=%h exp=%h", st[d], $time, xfer_cnt_w[d], m_cnt[d]);
        end
        if (hold[d]) begin
          total++;
          if (out_valid_w[d] !== 1'b1 || {out_mode_w[d], imm_out_w[d]} !== hold_v[d]) begin
            bad++;
            $display("FAIL sb_stall_hold[S=%0d] t=%0t got=%b/%h exp=1/%h", st[d], $time,
                     out_valid_w[d], {out_mode_w[d], imm_out_w[d]}, hold_v[d]);
          end
        end
        if (out_valid_w[d] !== 1'b0) begin
          total++;
          if (out_valid_w[d] !== 1'b1 || sbq[d].size() == 0) begin
            bad++;
            $display("FAIL sb_spurious_valid[S=%0d] t=%0t got=%b queued=%0d", st[d], $time,
                     out_valid_w[d], sbq[d].size());
          end else if ({out_mode_w[d], imm_out_w[d]} !== sbq[d][0]) begin
            bad++;
            $display("FAIL sb_data[S=%0d] t=%0t got=%h exp=%h", st[d], $time,
                     {out_mode_w[d], imm_out_w[d]}, sbq[d][0]);
          end
          if (out_valid_w[d] === 1'b1 && out_ready) begin
            if (sbq[d].size() > 0) void'(sbq[d].pop_front());
            m_cnt[d] = m_cnt[d] + 16'd1;
          end
        end
        hold[d]   = (out_valid_w[d] === 1'b1) && !out_ready;
        hold_v[d] = {out_mode_w[d], imm_out_w[d]};
        if (in_valid && in_ready_w[d] === 1'b1) sbq[d].push_back({mode, ref_ext(imm_in, mode)});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (out_valid_w[d] !== 1'b0 || imm_out_w[d] !== 32'h0 || out_mode_w[d] !== 2'b00 ||
          xfer_cnt_w[d] !== 16'h0 || in_ready_w[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state[S=%0d] got v=%b d=%h m=%b c=%h r=%b exp v=0 d=0 m=0 c=0 r=1",
                 st[d], out_valid_w[d], imm_out_w[d], out_mode_w[d], xfer_cnt_w[d], in_ready_w[d]);
      end
    end
  endtask

  task automatic test_modes();
    logic [15:0] vi [7] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0001, 16'h8000};
    logic [1:0]  vm [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] vo [7] = '{32'h00008001, 32'hFFFF8001, 32'h00007FFF, 32'h12340000,
                            32'hFFFFFFFC, 32'h00000004, 32'hFFFE0000};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      logic [31:0] exp;
      if (i < 7) begin
        imm_in = vi[i];
        mode = vm[i];
        exp = vo[i];
      end else begin
        imm_in = 16'($urandom);
        mode = 2'($urandom);
        exp = ref_ext(imm_in, mode);
      end
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid_w[0] !== 1'b1 || imm_out_w[0] !== exp || out_mode_w[0] !== mode) begin
        bad++;
        $display("FAIL mode_vec%0d got v=%b d=%h m=%b exp v=1 d=%h m=%b",
                 i, out_valid_w[0], imm_out_w[0], out_mode_w[0], exp, mode);
      end
      cycle();
      cycle();
      cycle();
    end
  endtask

  task automatic test_latency();
    int lat [3];
    do_reset();
    out_ready = 1'b1;
    lat = '{-1, -1, -1};
    imm_in = 16'($urandom);
    mode = 2'd1;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (out_valid_w[d] === 1'b1 && lat[d] < 0) lat[d] = c;
      cycle();
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lat[d] != st[d] - 1) begin
        bad++;
        $display("FAIL latency[S=%0d] got=%0d exp=%0d", st[d], lat[d], st[d] - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] nxt;
    logic [15:0] got [$];
    int gaps;
    bit flowing;
    do_reset();
    out_ready = 1'b0;
    mode = 2'd1;
    nxt = 16'd1;
    imm_in = nxt;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (in_ready_w[1] !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready_full got=%b exp=0", in_ready_w[1]);
        end
      end
      if (in_ready_w[1] === 1'b1) nxt = nxt + 16'd1;
      cycle();
      imm_in = nxt;
    end
    out_ready = 1'b1;
    gaps = 0;
    flowing = 0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      in_valid = (nxt <= 16'd4);
      imm_in = nxt;
      @(negedge clk);
      if (out_valid_w[1] === 1'b1) begin
        got.push_back(imm_out_w[1][15:0]);
        flowing = 1;
      end else if (flowing) begin
        gaps++;
      end
      if (in_valid && in_ready_w[1] === 1'b1) nxt = nxt + 16'd1;
      cycle();
    end
    in_valid = 1'b0;
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL bp_out_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== 16'(i + 1)) begin
        bad++;
        $display("FAIL bp_order%0d got=%h exp=%h", i, got[i], 16'(i + 1));
      end
    end
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL bp_gaps got=%0d exp=0", gaps);
    end
    @(negedge clk);
    total++;
    if (xfer_cnt_w[1] !== 16'd4) begin
      bad++;
      $display("FAIL bp_xfer_cnt got=%0d exp=4", xfer_cnt_w[1]);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    w = 0;
    imm_in = 16'($urandom);
    mode = 2'($urandom);
    @(negedge clk);
    while (out_valid_w[2] !== 1'b1 && w < 10) begin
      cycle();
      imm_in = 16'($urandom);
      mode = 2'($urandom);
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 10) begin
      bad++;
      $display("FAIL b2b_fill_timeout got=%0d cycles exp<10", w);
    end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (in_ready_w[2] !== 1'b1 || out_valid_w[2] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_cycle%0d got r=%b v=%b exp r=1 v=1", c, in_ready_w[2], out_valid_w[2]);
      end
      cycle();
      imm_in = 16'($urandom);
      mode = 2'($urandom);
      @(negedge clk);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic [31:0] exp;
    int lat;
    do_reset();
    out_ready = 1'b0;
    mode = 2'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      imm_in = 16'($urandom);
      cycle();
    end
    rst = 1'b1;
    imm_in = 16'hBEEF;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid_w[2] !== 1'b0 || xfer_cnt_w[2] !== 16'h0 || imm_out_w[2] !== 32'h0 ||
        in_ready_w[2] !== 1'b1) begin
      bad++;
      $display("FAIL rst_inflight got v=%b c=%h d=%h r=%b exp v=0 c=0 d=0 r=1",
               out_valid_w[2], xfer_cnt_w[2], imm_out_w[2], in_ready_w[2]);
    end
    cycle();
    out_ready = 1'b1;
    imm_in = 16'($urandom);
    mode = 2'd3;
    exp = ref_ext(imm_in, mode);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (out_valid_w[2] === 1'b1) begin
        lat = c;
        total++;
        if (imm_out_w[2] !== exp) begin
          bad++;
          $display("FAIL rst_post_data got=%h exp=%h", imm_out_w[2], exp);
        end
      end
      cycle();
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL rst_post_latency got=%0d exp=3", lat);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      imm_in    = 16'($urandom);
      mode      = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (sbq[d].size() != 0 || out_valid_w[d] !== 1'b0) begin
        bad++;
        $display("FAIL rand_drain[S=%0d] got queued=%0d v=%b exp 0/0", st[d], sbq[d].size(), out_valid_w[d]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    int guard;
    logic [15:0] exp_seq [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    mode = 2'd0;
    n = 0;
    guard = 0;
    while (n < 65535 && guard < 70000) begin
      imm_in = 16'($urandom);
      @(negedge clk);
      if (out_valid_w[0] === 1'b1) n++;
      guard++;
      cycle();
    end
    total++;
    if (n < 65535) begin
      bad++;
      $display("FAIL wrap_timeout got=%0d transfers exp=65535", n);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (xfer_cnt_w[0] !== exp_seq[i]) begin
        bad++;
        $display("FAIL wrap_cnt%0d got=%h exp=%h", i, xfer_cnt_w[0], exp_seq[i]);
      end
      cycle();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imm_ext_pipe

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It accepts an IN_W-bit immediate plus a mode code, and produces an OUT_W-bit operand: zero-extended, sign-extended, upper-loaded (LUI) or branch-offset (sign-extend then shift left 2). It sits between decode and the ALU/branch-target adder, with a valid/ready handshake on both sides and STAGES register stages that stall cleanly under backpressure.

## Interface
- IN_W, 16, immediate input width; legal range 2..OUT_W-1.
- OUT_W, 32, extended output width; OUT_W > IN_W.
- STAGES, 1, pipeline depth; legal range 1..4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  imm_in and mode are valid this cycle.
- in_ready  out  1  unit accepts input this cycle.
- imm_in  in  IN_W  raw immediate field.
- mode  in  2  extension mode: 00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH.
- out_valid  out  1  imm_out holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- imm_out  out  OUT_W  extended result.
- out_mode  out  2  mode code that travelled with the result.
- xfer_cnt  out  16  count of completed output transfers; wraps.

## Operation
- Extension is combinational at the input and captured into stage 0. Later stages only move data.
- ZERO: the upper OUT_W-IN_W bits are 0, and the low bits are imm_in.
- SIGN: the upper bits are replicated imm_in[IN_W-1].
- UPPER: imm_in is placed at bits [OUT_W-1 : OUT_W-IN_W], and the low bits are 0.
- BRANCH: imm_in is sign-extended to OUT_W, then shifted left by 2. The top 2 bits of that value are discarded, so the result is truncated to OUT_W bits.
- Each stage k holds valid[k], data[k] and mode[k].
- Stage k advances when it is empty, or when the next stage advances. The last stage advances when out_ready is high.
- in_ready = ~valid[0] | adv[0]. This value is combinational from out_ready through the stage valids.
- An input transfer happens when in_valid & in_ready.
- An output transfer happens when out_valid & out_ready. On each output transfer, xfer_cnt increments by 1 and wraps from 0xFFFF to 0.
- out_valid, imm_out and out_mode come directly from the last stage.
- When out_valid is 0, imm_out and out_mode hold their last value. They are 0 after reset.
- Results leave in strict FIFO order. No result is dropped or duplicated.
- Reset:
  - clears all valid bits, stage data and modes, and xfer_cnt to 0.
  - in-flight items are discarded, and out_valid is 0 in the cycle after rst is sampled high.
  - in_ready is 1 from the first cycle after reset.
  - inputs presented while rst is high are ignored.

## Timing
- Latency: an item accepted at edge N appears on out_valid at edge N+STAGES-1 when there are no stalls. With STAGES=1, it is visible in the cycle after acceptance.
- Throughput: 1 item per cycle while out_ready stays high.
- Backpressure:
  - with out_ready low, the pipe fills.
  - after STAGES items are held, in_ready drops the same cycle the last stage blocks.
  - stalled stages hold data and mode stable.
- Simultaneous accept and emit when full: when out_ready is high in a full pipe, in_ready is also high in the same cycle. A new item is accepted and no bubble is inserted.
- out_valid must never fall without a transfer. imm_out must not change while out_valid=1 and out_ready=0.
- When the mode is out of range, nothing special applies; all 2-bit codes are defined.

## Structure
- Shared package/header:
  - mode codes MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH.
  - the counter width constant XFER_CNT_W=16.
- Natural sub-module: imm_ext_core, a purely combinational function of (imm_in, mode), parametrised by IN_W and OUT_W. It is instantiated once ahead of stage 0 and is unit-testable alone.
- Pipeline stages come from a generate loop over STAGES, not separate modules.

## Test plan
- Default params, out_ready=1: ZERO 0x8001 -> 0x00008001; SIGN 0x8001 -> 0xFFFF8001; SIGN 0x7FFF -> 0x00007FFF. Each result appears 1 cycle after acceptance.
- UPPER 0x1234 -> 0x12340000. BRANCH 0xFFFF -> 0xFFFFFFFC. BRANCH 0x0001 -> 0x00000004. BRANCH 0x8000 -> 0xFFFE0000. out_mode matches the input mode each time.
- STAGES=2, stream 0x0001..0x0004 in SIGN mode, hold out_ready=0 for 3 cycles:
  - in_ready is 0 after 2 accepts.
  - on release, outputs arrive in order 1,2,3,4 with no gaps once flowing.
  - xfer_cnt = 4.
- STAGES=4, full pipe, out_ready=1 and in_valid=1 continuously for 10 cycles: exactly one accept and one emit each cycle, and in_ready never falls.
- Assert rst for 1 cycle with 3 items in flight: next cycle out_valid=0, xfer_cnt=0, imm_out=0, in_ready=1. The next accepted item emerges after the nominal latency.
- Preload xfer_cnt near wrap by performing 65535 transfers, then 2 more: the count reads 0xFFFF, then 0x0000, then 0x0001.
